i2c_scl_gen: RTL and testbench
==============================

# i2c_scl_gen

SCL bit-timing generator for the I2C controller. It sits directly downstream of the free-running enable counter and feeds the bit/byte engine. It divides the system clock into four quarter-phases per I2C bit, drives the open-drain SCL enable, and emits phase ticks for data change and sample points. Optional clock-stretching support holds the high phase until the bus actually reads high.

## Interface
Parameters:
- DIV_WIDTH, 8, width of the quarter-period divisor and internal phase timer.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clock.
- en  in  1  run request; high = generate bits continuously.
- div  in  DIV_WIDTH  quarter-period length minus 1, in clock cycles.
- scl_in  in  1  SCL bus level, already synchronized upstream.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- phase  out  2  current quarter: 0 = LOW_A, 1 = LOW_B, 2 = HIGH_A, 3 = HIGH_B.
- tick  out  1  one-cycle pulse in the first cycle of every phase.
- bit_done  out  1  one-cycle pulse in the last cycle of HIGH_B.
- busy  out  1  high whenever state is not IDLE.
- stretching  out  1  high while HIGH_A waits for scl_in to go high.

## Operation
- States: IDLE, LOW_A, LOW_B, HIGH_A, HIGH_B.
- IDLE: scl_oe=0, phase=0, no ticks. If en=1, go to LOW_A next cycle.
- Divisor: div is latched into div_q on every entry to LOW_A. A change to div mid-bit has no effect until the next bit.
- Phase timer:
  - Cleared on every phase entry.
  - Increments once per cycle.
  - The phase ends in the cycle where the count equals div_q.
  - Each phase lasts div_q+1 cycles. div=0 gives 1-cycle phases.
- Transitions:
  - LOW_A → LOW_B → HIGH_A → HIGH_B.
  - HIGH_B end with en=1: back-to-back to LOW_A, no idle gap.
  - HIGH_B end with en=0: go to IDLE.
- en deasserted mid-bit is ignored until HIGH_B completes. A bit is never truncated.
- scl_oe is 1 in LOW_A/LOW_B and 0 in HIGH_A/HIGH_B/IDLE.
- The bit engine:
  - changes SDA on the tick entering LOW_B;
  - samples SDA on the tick entering HIGH_B.
- All outputs are registered. There is no combinational path from input to output.

## Timing
- Reset values: scl_oe=0, phase=0, tick=0, bit_done=0, busy=0, stretching=0, state=IDLE, timer=0.
- Reset wins over every other event, including mid-phase and during a stretch.
- Start latency: en sampled high in IDLE at edge N gives LOW_A at edge N+1 with tick=1, scl_oe=1, busy=1.
- Bit period without stretch: 4·(div_q+1) cycles.
- bit_done coincides with the last HIGH_B cycle. When running back-to-back, the next cycle is LOW_A with tick=1.
- Timer width is DIV_WIDTH. The maximum phase is 2^DIV_WIDTH cycles (div all ones), and the timer never wraps within a phase.

## Configuration
- Macro: I2C_SCL_STRETCH_EN.
- Defined:
  - In HIGH_A the timer holds at 0 and stretching=1 while scl_in=0.
  - Counting starts in the first cycle scl_in is seen high. HIGH_A's tick still fires on phase entry.
  - Stretch duration is unbounded. Only reset or scl_in high ends it.
- Undefined:
  - scl_in is ignored and stretching is tied to 0.
  - HIGH_A counts immediately.

## Structure
- Package i2c_pkg:
  - phase encoding constants PH_LOW_A, PH_LOW_B, PH_HIGH_A, PH_HIGH_B;
  - state enum/localparams for the SCL FSM, shared with the bit engine.
- One sub-module, i2c_phase_timer:
  - ports clock, reset_n, clear, hold, limit;
  - outputs count and done (count==limit).
  - The FSM stays in i2c_scl_gen.

## Test plan
- Reset: assert reset_n=0 for 3 cycles mid-HIGH_A → all outputs 0, state IDLE on the next edge. Release with en=1 → LOW_A tick one cycle later.
- Free run: div=3, en=1 → tick every 4 cycles, bit_done every 16 cycles. scl_oe is low for 8 cycles then released for 8.
- Minimum divisor: div=0 → phase sequences 0,1,2,3 each cycle and tick is constant 1. bit_done asserts every 4th cycle.
- Mid-bit stop and divisor change:
  - div=3, drop en during LOW_B → HIGH_B completes, then IDLE with busy=0.
  - Change div to 7 mid-bit → the old bit stays 16 cycles, the next bit is 32 cycles.
- Stretch (macro defined): div=3, hold scl_in=0 for 10 cycles after HIGH_A entry → stretching high for 10 cycles, bit period 26 cycles.
- Stretch (macro undefined): same stimulus → bit period 16 cycles, stretching stays 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C SCL timing generator and the bit engine.
// Phase codes match the phase output; state codes are shared with the bit engine.
package i2c_pkg;

    localparam logic [1:0] PH_LOW_A  = 2'd0;
    localparam logic [1:0] PH_LOW_B  = 2'd1;
    localparam logic [1:0] PH_HIGH_A = 2'd2;
    localparam logic [1:0] PH_HIGH_B = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOW_A  = 3'd1,
        ST_LOW_B  = 3'd2,
        ST_HIGH_A = 3'd3,
        ST_HIGH_B = 3'd4
    } scl_state_t;

endpackage

// File: rtl/i2c_scl_gen_timer.sv
// Quarter-phase timer for the SCL generator: counts up from 0 and flags count == limit.
// clear wins over hold; the owner clears it on every phase entry so it never wraps.
module i2c_phase_timer
    import i2c_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 hold,
    input  logic [DIV_WIDTH-1:0] limit,
    output logic [DIV_WIDTH-1:0] count,
    output logic                 done
);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!hold) begin
            count <= count + DIV_WIDTH'(1);
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/i2c_scl_gen.sv
// SCL bit-timing generator: four quarter-phases per bit, open-drain enable and phase ticks.
// Clock stretching in HIGH_A is compiled in only when I2C_SCL_STRETCH_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | SCL released, waiting for en
//   ST_LOW_A  | SCL pulled low, first quarter (div latched on entry)
//   ST_LOW_B  | SCL pulled low, SDA change point on entry
//   ST_HIGH_A | SCL released, may wait for bus to read high
//   ST_HIGH_B | SCL released, SDA sample point on entry
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 scl_in,
    output logic                 scl_oe,
    output logic [1:0]           phase,
    output logic                 tick,
    output logic                 bit_done,
    output logic                 busy,
    output logic                 stretching
);

    scl_state_t           state;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] count;
    logic                 done;
    logic                 hold;
    logic                 phase_end;
    logic                 clear;

`ifdef I2C_SCL_STRETCH_EN
    logic stretch_q;
    assign hold       = stretch_q;
    assign stretching = stretch_q;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold          = 1'b0;
    assign stretching    = 1'b0;
`endif

    // A held timer sits at 0, which equals div_q when div is 0; hold must block the end.
    assign phase_end = done && !hold && (state != ST_IDLE);
    assign clear     = phase_end || (state == ST_IDLE);

    i2c_phase_timer #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (clear),
        .hold   (hold),
        .limit  (div_q),
        .count  (count),
        .done   (done)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            div_q    <= '0;
            scl_oe   <= 1'b0;
            phase    <= PH_LOW_A;
            tick     <= 1'b0;
            bit_done <= 1'b0;
            busy     <= 1'b0;
`ifdef I2C_SCL_STRETCH_EN
            stretch_q <= 1'b0;
`endif
        end else begin
            tick     <= 1'b0;
            bit_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state  <= ST_LOW_A;
                        div_q  <= div;
                        phase  <= PH_LOW_A;
                        tick   <= 1'b1;
                        scl_oe <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_LOW_A: begin
                    if (phase_end) begin
                        state <= ST_LOW_B;
                        phase <= PH_LOW_B;
                        tick  <= 1'b1;
                    end
                end
                ST_LOW_B: begin
                    if (phase_end) begin
                        state  <= ST_HIGH_A;
                        phase  <= PH_HIGH_A;
                        tick   <= 1'b1;
                        scl_oe <= 1'b0;
`ifdef I2C_SCL_STRETCH_EN
                        stretch_q <= !scl_in;
`endif
                    end
                end
                ST_HIGH_A: begin
                    if (phase_end) begin
                        state    <= ST_HIGH_B;
                        phase    <= PH_HIGH_B;
                        tick     <= 1'b1;
                        bit_done <= (div_q == '0);
                    end
`ifdef I2C_SCL_STRETCH_EN
                    else begin
                        // Once the bus has been seen high the phase counts out normally.
                        stretch_q <= stretch_q && !scl_in;
                    end
`endif
                end
                ST_HIGH_B: begin
                    if (phase_end) begin
                        tick  <= en;
                        phase <= PH_LOW_A;
                        if (en) begin
                            state  <= ST_LOW_A;
                            div_q  <= div;
                            scl_oe <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_done <= ((count + DIV_WIDTH'(1)) == div_q);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    phase  <= PH_LOW_A;
                    scl_oe <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen; expectations follow I2C_SCL_STRETCH_EN when it is defined.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_i2c_scl_gen;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] div;
    logic       scl_in;
    logic       scl_oe;
    logic [1:0] phase;
    logic       tick;
    logic       bit_done;
    logic       busy;
    logic       stretching;

    int checks = 0;
    int errors = 0;

`ifdef I2C_SCL_STRETCH_EN
    localparam int STRETCH_EXP = 10;
`else
    localparam int STRETCH_EXP = 0;
`endif

    i2c_scl_gen #(.DIV_WIDTH(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .div       (div),
        .scl_in    (scl_in),
        .scl_oe    (scl_oe),
        .phase     (phase),
        .tick      (tick),
        .bit_done  (bit_done),
        .busy      (busy),
        .stretching(stretching)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " scl_oe"},     32'(scl_oe),     32'd0);
        chk({tag, " phase"},      32'(phase),      32'd0);
        chk({tag, " tick"},       32'(tick),       32'd0);
        chk({tag, " bit_done"},   32'(bit_done),   32'd0);
        chk({tag, " busy"},       32'(busy),       32'd0);
        chk({tag, " stretching"}, 32'(stretching), 32'd0);
    endtask

    // Checks one whole bit starting at its first LOW_A cycle; returns one cycle past HIGH_B.
    task automatic run_bit(input int d, input int next_div, input int stim_ns,
                           input int exp_ns, input int drop_at);
        int len [4];
        int total;
        len[0] = d + 1;
        len[1] = d + 1;
        len[2] = d + 1 + exp_ns;
        len[3] = d + 1;
        total  = len[0] + len[1] + len[2] + len[3];
        for (int j = 0; j < total; j++) begin
            int ph;
            int k;
            string tag;
            ph = 0;
            k  = j;
            while (k >= len[ph]) begin
                k  = k - len[ph];
                ph = ph + 1;
            end
            tag = $sformatf("d%0d cyc%0d", d, j);
            chk({tag, " phase"},      32'(phase),      32'(ph));
            chk({tag, " tick"},       32'(tick),       32'(k == 0));
            chk({tag, " scl_oe"},     32'(scl_oe),     32'(ph < 2));
            chk({tag, " bit_done"},   32'(bit_done),   32'(ph == 3 && k == d));
            chk({tag, " busy"},       32'(busy),       32'd1);
            chk({tag, " stretching"}, 32'(stretching), 32'(ph == 2 && k < exp_ns));
            if (j == 0) div = 8'(next_div);
            if (j == drop_at) en = 1'b0;
            if (stim_ns > 0 && j == 2 * (d + 1) - 1) scl_in = 1'b0;
            if (stim_ns > 0 && j == 2 * (d + 1) + stim_ns - 1) scl_in = 1'b1;
            @(negedge clock);
        end
        scl_in = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        div     = 8'd3;
        scl_in  = 1'b1;
        repeat (3) @(negedge clock);
        chk_idle("por");

        reset_n = 1'b1;
        en      = 1'b1;
        @(negedge clock);
        chk("start tick",   32'(tick),   32'd1);
        chk("start scl_oe", 32'(scl_oe), 32'd1);
        chk("start busy",   32'(busy),   32'd1);

        // free run at div 3, then a mid-bit change to 7 that lands on the following bit
        run_bit(3, 3, 0, 0, -1);
        run_bit(3, 7, 0, 0, -1);
        run_bit(7, 0, 0, 0, -1);
        // minimum divisor: every cycle is a new phase
        run_bit(0, 0, 0, 0, -1);
        run_bit(0, 3, 0, 0, -1);
        // bus held low for 10 sampled edges from HIGH_A entry
        run_bit(3, 3, 10, STRETCH_EXP, -1);
        // en dropped during LOW_B: bit completes, then idle
        run_bit(3, 3, 0, 0, 5);
        chk_idle("stop");
        repeat (2) @(negedge clock);
        chk("stop stays idle busy",   32'(busy),   32'd0);
        chk("stop stays idle scl_oe", 32'(scl_oe), 32'd0);

        // reset mid-HIGH_A
        en = 1'b1;
        @(negedge clock);
        chk("restart tick", 32'(tick), 32'd1);
        repeat (9) @(negedge clock);
        chk("pre-reset phase", 32'(phase), 32'd2);
        reset_n = 1'b0;
        @(negedge clock);
        chk("reset next edge busy",  32'(busy),  32'd0);
        chk("reset next edge phase", 32'(phase), 32'd0);
        repeat (2) @(negedge clock);
        chk_idle("mid reset");
        reset_n = 1'b1;
        @(negedge clock);
        chk("release tick",   32'(tick),   32'd1);
        chk("release scl_oe", 32'(scl_oe), 32'd1);
        chk("release busy",   32'(busy),   32'd1);
        chk("release phase",  32'(phase),  32'd0);
        run_bit(3, 3, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
